// File: rtl/decode_stage.sv
// RV32I decode stage: classifies the incoming word, extracts fields and the immediate,
// and holds the result in a one-deep valid/ready register with load-use stall insertion.
module decode_stage #(
  parameter int IMM_W     = 32,
  parameter bit W_OPS     = 1'b0,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      pc_out,
  output logic [2:0]       type_out,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [IMM_W-1:0] imm,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             jump,
  output logic             alu_src_imm,
  output logic             illegal
);

  typedef enum logic [2:0] {
    T_R   = 3'd0,
    T_I   = 3'd1,
    T_S   = 3'd2,
    T_SB  = 3'd3,
    T_UJ  = 3'd4,
    T_U   = 3'd5,
    T_ILL = 3'd7
  } inst_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]       opcode;
  inst_type_e       type_next;
  logic             is_r, is_i, is_s, is_sb, is_uj, is_u, is_ill;
  logic             uses_rs1, uses_rs2;
  logic [31:0]      imm32;
  logic [IMM_W-1:0] imm_next;
  logic [4:0]       rs1_next, rs2_next, rd_next;
  logic [2:0]       funct3_next;
  logic [6:0]       funct7_next;
  logic             reg_write_next, mem_read_next, mem_write_next;
  logic             branch_next, jump_next, alu_src_imm_next;
  logic             hazard, accept;

  logic             out_valid_reg;
  logic             ld_valid_reg;
  logic [4:0]       ld_rd_reg;
  logic [31:0]      pc_reg;
  logic [2:0]       type_reg;
  logic [4:0]       rs1_reg, rs2_reg, rd_reg;
  logic [2:0]       funct3_reg;
  logic [6:0]       funct7_reg;
  logic [IMM_W-1:0] imm_reg;
  logic             reg_write_reg, mem_read_reg, mem_write_reg;
  logic             branch_reg, jump_reg, alu_src_imm_reg, illegal_reg;

  assign opcode = inst[6:0];

  always_comb begin
    type_next = T_ILL;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OP_REG:                                        type_next = T_R;
        OP_REG32:                                      type_next = W_OPS ? T_R : T_ILL;
        OP_LOAD, OP_IMM, OP_JALR, OP_FENCE, OP_SYSTEM: type_next = T_I;
        OP_IMM32:                                      type_next = W_OPS ? T_I : T_ILL;
        OP_STORE:                                      type_next = T_S;
        OP_BRANCH:                                     type_next = T_SB;
        OP_JAL:                                        type_next = T_UJ;
        OP_LUI, OP_AUIPC:                              type_next = T_U;
        default:                                       type_next = T_ILL;
      endcase
    end
  end

  assign is_r   = (type_next == T_R);
  assign is_i   = (type_next == T_I);
  assign is_s   = (type_next == T_S);
  assign is_sb  = (type_next == T_SB);
  assign is_uj  = (type_next == T_UJ);
  assign is_u   = (type_next == T_U);
  assign is_ill = (type_next == T_ILL);

  assign uses_rs1 = is_r | is_i | is_s | is_sb;
  assign uses_rs2 = is_r | is_s | is_sb;

  always_comb begin
    imm32 = '0;
    case (type_next)
      T_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
      T_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      T_SB:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U:     imm32 = {inst[31:12], 12'b0};
      T_UJ:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_next = IMM_W'($signed(imm32));

  // U/UJ formats carry no funct3 field, so it is reported as zero for them.
  assign rs1_next    = uses_rs1 ? inst[19:15] : 5'd0;
  assign rs2_next    = uses_rs2 ? inst[24:20] : 5'd0;
  assign rd_next     = (is_r | is_i | is_u | is_uj) ? inst[11:7] : 5'd0;
  assign funct3_next = uses_rs1 ? inst[14:12] : 3'd0;
  assign funct7_next = is_r ? inst[31:25] : 7'd0;

  assign reg_write_next   = (is_r | is_i | is_u | is_uj) && (opcode != OP_FENCE);
  assign mem_read_next    = is_i && (opcode == OP_LOAD);
  assign mem_write_next   = is_s;
  assign branch_next      = is_sb;
  assign jump_next        = is_uj | (is_i && (opcode == OP_JALR));
  assign alu_src_imm_next = is_i | is_s | is_u | is_uj;

  // Source indices are compared straight from the instruction word, gated by usage.
  logic [1:0]      src_uses;
  logic [1:0][4:0] src_idx;
  logic [1:0]      src_hit;

  assign src_uses = {uses_rs2, uses_rs1};
  assign src_idx  = {inst[24:20], inst[19:15]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
      assign src_hit[gi] = src_uses[gi] && (src_idx[gi] == ld_rd_reg);
    end
  endgenerate

  assign hazard   = HAZARD_EN && ld_valid_reg && in_valid && (|src_hit);
  assign in_ready = !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg   <= 1'b0;
      ld_valid_reg    <= 1'b0;
      ld_rd_reg       <= '0;
      pc_reg          <= '0;
      type_reg        <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
      funct3_reg      <= '0;
      funct7_reg      <= '0;
      imm_reg         <= '0;
      reg_write_reg   <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      branch_reg      <= 1'b0;
      jump_reg        <= 1'b0;
      alu_src_imm_reg <= 1'b0;
      illegal_reg     <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      ld_valid_reg  <= 1'b0;
    end else if (accept) begin
      out_valid_reg   <= 1'b1;
      ld_valid_reg    <= mem_read_next && (rd_next != 5'd0);
      ld_rd_reg       <= rd_next;
      pc_reg          <= pc;
      type_reg        <= type_next;
      rs1_reg         <= rs1_next;
      rs2_reg         <= rs2_next;
      rd_reg          <= rd_next;
      funct3_reg      <= funct3_next;
      funct7_reg      <= funct7_next;
      imm_reg         <= imm_next;
      reg_write_reg   <= reg_write_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      branch_reg      <= branch_next;
      jump_reg        <= jump_next;
      alu_src_imm_reg <= alu_src_imm_next;
      illegal_reg     <= is_ill;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
      ld_valid_reg  <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign pc_out      = pc_reg;
  assign type_out    = type_reg;
  assign rs1         = rs1_reg;
  assign rs2         = rs2_reg;
  assign rd          = rd_reg;
  assign funct3      = funct3_reg;
  assign funct7      = funct7_reg;
  assign imm         = imm_reg;
  assign reg_write   = reg_write_reg;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;
  assign branch      = branch_reg;
  assign jump        = jump_reg;
  assign alu_src_imm = alu_src_imm_reg;
  assign illegal     = illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two configurations share one stimulus stream, each with its
// own scoreboard fed at accept time and checked when the held result is consumed.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] inst, pc;

  always #5 clk = ~clk;

  // Instance a: W_OPS=0, HAZARD_EN=1, IMM_W=32.
  logic        in_ready_a, out_valid_a;
  logic [31:0] pc_out_a;
  logic [2:0]  type_a, funct3_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [6:0]  funct7_a;
  logic [31:0] imm_a;
  logic        reg_write_a, mem_read_a, mem_write_a, branch_a, jump_a, alu_src_imm_a, illegal_a;

  // Instance b: W_OPS=1, HAZARD_EN=0, IMM_W=40.
  logic        in_ready_b, out_valid_b;
  logic [31:0] pc_out_b;
  logic [2:0]  type_b, funct3_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [6:0]  funct7_b;
  logic [39:0] imm_b;
  logic        reg_write_b, mem_read_b, mem_write_b, branch_b, jump_b, alu_src_imm_b, illegal_b;

  decode_stage #(.IMM_W(32), .W_OPS(1'b0), .HAZARD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .inst(inst), .pc(pc),
    .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready), .pc_out(pc_out_a),
    .type_out(type_a), .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .funct3(funct3_a),
    .funct7(funct7_a), .imm(imm_a), .reg_write(reg_write_a), .mem_read(mem_read_a),
    .mem_write(mem_write_a), .branch(branch_a), .jump(jump_a), .alu_src_imm(alu_src_imm_a),
    .illegal(illegal_a)
  );

  decode_stage #(.IMM_W(40), .W_OPS(1'b1), .HAZARD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .inst(inst), .pc(pc),
    .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready), .pc_out(pc_out_b),
    .type_out(type_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .funct3(funct3_b),
    .funct7(funct7_b), .imm(imm_b), .reg_write(reg_write_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .branch(branch_b), .jump(jump_b), .alu_src_imm(alu_src_imm_b),
    .illegal(illegal_b)
  );

  typedef struct packed {
    logic [2:0]  typ;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [6:0]  ctrl;  // reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal
    logic [31:0] pc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input bit w_ops);
    exp_t        e;
    logic [6:0]  op;
    logic [31:0] im;
    op = i[6:0];
    e = '0;
    e.pc = p;
    e.typ = 3'd7;
    if (i[1:0] == 2'b11) begin
      case (op)
        7'h33: e.typ = 3'd0;
        7'h3B: e.typ = w_ops ? 3'd0 : 3'd7;
        7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: e.typ = 3'd1;
        7'h1B: e.typ = w_ops ? 3'd1 : 3'd7;
        7'h23: e.typ = 3'd2;
        7'h63: e.typ = 3'd3;
        7'h6F: e.typ = 3'd4;
        7'h37, 7'h17: e.typ = 3'd5;
        default: e.typ = 3'd7;
      endcase
    end
    case (e.typ)
      3'd1: im = {{20{i[31]}}, i[31:20]};
      3'd2: im = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3: im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4: im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5: im = {i[31:12], 12'h000};
      default: im = 32'h0;
    endcase
    e.imm = {{32{im[31]}}, im};
    if (e.typ <= 3'd3) begin
      e.rs1 = i[19:15];
      e.f3  = i[14:12];
    end
    if (e.typ == 3'd0 || e.typ == 3'd2 || e.typ == 3'd3) e.rs2 = i[24:20];
    if (e.typ == 3'd0 || e.typ == 3'd1 || e.typ == 3'd4 || e.typ == 3'd5) e.rd = i[11:7];
    if (e.typ == 3'd0) e.f7 = i[31:25];
    if (e.typ == 3'd7) begin
      e.ctrl = 7'b0000001;
    end else begin
      e.ctrl[6] = (e.typ != 3'd2 && e.typ != 3'd3) && (op != 7'h0F);
      e.ctrl[5] = (op == 7'h03);
      e.ctrl[4] = (e.typ == 3'd2);
      e.ctrl[3] = (e.typ == 3'd3);
      e.ctrl[2] = (e.typ == 3'd4) || (op == 7'h67);
      e.ctrl[1] = (e.typ != 3'd0 && e.typ != 3'd3);
      e.ctrl[0] = 1'b0;
    end
    return e;
  endfunction

  task automatic cmp_txn(input string who, input exp_t g, input exp_t e);
    $display("%s txn pc=%08h type=%0d rd=%0d imm=%0h", who, e.pc, e.typ, e.rd, e.imm);
    check({who, "_type"}, 64'(g.typ), 64'(e.typ));
    check({who, "_rs1"},  64'(g.rs1), 64'(e.rs1));
    check({who, "_rs2"},  64'(g.rs2), 64'(e.rs2));
    check({who, "_rd"},   64'(g.rd),  64'(e.rd));
    check({who, "_f3"},   64'(g.f3),  64'(e.f3));
    check({who, "_f7"},   64'(g.f7),  64'(e.f7));
    check({who, "_imm"},  g.imm,      e.imm);
    check({who, "_ctrl"}, 64'(g.ctrl), 64'(e.ctrl));
    check({who, "_pc"},   64'(g.pc),  64'(e.pc));
  endtask

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t got_a, got_b, exp_a, exp_b;

  // Scoreboards: pop on consume, then push on accept (the accept takes effect next edge).
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (out_valid_a && out_ready) begin
        got_a = {type_a, rs1_a, rs2_a, rd_a, funct3_a, funct7_a, 64'($signed(imm_a)),
                 reg_write_a, mem_read_a, mem_write_a, branch_a, jump_a, alu_src_imm_a,
                 illegal_a, pc_out_a};
        if (q_a.size() == 0) check("a_unexpected_out", 64'(q_a.size()), 64'd1);
        else begin
          exp_a = q_a.pop_front();
          cmp_txn("a", got_a, exp_a);
        end
      end
      if (out_valid_b && out_ready) begin
        got_b = {type_b, rs1_b, rs2_b, rd_b, funct3_b, funct7_b, 64'($signed(imm_b)),
                 reg_write_b, mem_read_b, mem_write_b, branch_b, jump_b, alu_src_imm_b,
                 illegal_b, pc_out_b};
        if (q_b.size() == 0) check("b_unexpected_out", 64'(q_b.size()), 64'd1);
        else begin
          exp_b = q_b.pop_front();
          cmp_txn("b", got_b, exp_b);
        end
      end
      if (flush) begin
        q_a.delete();
        q_b.delete();
      end else begin
        if (in_valid && in_ready_a) q_a.push_back(model(inst, pc, 1'b0));
        if (in_valid && in_ready_b) q_b.push_back(model(inst, pc, 1'b1));
      end
    end
  end

  // Present one instruction until instance a takes it; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p, output int waited);
    waited = 0;
    inst = i;
    pc = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_a && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("send_accept", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] ADD_X6 = 32'h00228333;
  localparam logic [31:0] ADDI_5 = 32'h00500093;

  logic [31:0] stream_inst [6] = '{32'h0020A223, 32'hFE208EE3, 32'h0080006F,
                                   32'h123452B7, 32'h0000000F, 32'h000080E7};
  logic [63:0] stream_imm  [6] = '{64'd4, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8,
                                   64'h12345000, 64'd0, 64'd0};
  logic [2:0]  stream_type [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd1};
  logic [4:0]  stream_rd   [6] = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd1};

  logic [31:0] ill_inst   [3] = '{32'h0000001B, 32'hFFFFFFFC, 32'h0000003B};
  logic [2:0]  ill_type_a [3] = '{3'd7, 3'd7, 3'd7};
  logic [2:0]  ill_type_b [3] = '{3'd1, 3'd7, 3'd0};
  logic        ill_flag_b [3] = '{1'b0, 1'b1, 1'b0};

  int w;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    inst = '0;
    pc = '0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_type",      64'(type_a), 64'd0);
    check("rst_imm",       64'(imm_a), 64'd0);
    check("rst_pc",        64'(pc_out_a), 64'd0);
    check("rst_ctrl",      64'({reg_write_a, alu_src_imm_a, illegal_a}), 64'd0);
    check("rst_out_valid_b", 64'(out_valid_b), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready_a), 64'd1);

    // addi x1,x0,5: visible the cycle after acceptance.
    send(ADDI_5, 32'h100, w);
    check("addi_valid", 64'(out_valid_a), 64'd1);
    check("addi_type",  64'(type_a), 64'd1);
    check("addi_rd",    64'(rd_a), 64'd1);
    check("addi_rs",    64'({rs1_a, rs2_a}), 64'd0);
    check("addi_imm",   64'(imm_a), 64'd5);
    check("addi_ctrl",  64'({reg_write_a, alu_src_imm_a}), 64'd3);

    // Back-to-back stream with no hazards: every send must go through without waiting.
    for (int k = 0; k < 6; k++) begin
      send(stream_inst[k], 32'h110 + 32'(k * 4), w);
      check("stream_wait", 64'(w), 64'd0);
      check("stream_imm",  64'($signed(imm_a)), stream_imm[k]);
      check("stream_type", 64'(type_a), 64'(stream_type[k]));
      check("stream_rd",   64'(rd_a), 64'(stream_rd[k]));
    end

    // Load-use: lw x5 then add x6,x5,x2.
    send(LW_X5, 32'h200, w);
    inst = ADD_X6;
    pc = 32'h210;
    in_valid = 1'b1;
    @(negedge clk);
    check("lu_stall_a",   64'(in_ready_a), 64'd0);
    check("lu_nostall_b", 64'(in_ready_b), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lu_bubble_a",  64'(out_valid_a), 64'd0);
    check("lu_ready_a",   64'(in_ready_a), 64'd1);
    check("lu_nogap_b",   64'(out_valid_b), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Backpressure while add is held; next instruction waits.
    out_ready = 1'b0;
    inst = 32'hFFF00393;
    pc = 32'h300;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready_a), 64'd0);
      check("bp_valid",    64'(out_valid_a), 64'd1);
      check("bp_pc",       64'(pc_out_a), 64'h210);
      check("bp_rd",       64'(rd_a), 64'd6);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rel_pc",  64'(pc_out_a), 64'h300);
    check("rel_imm", 64'($signed(imm_a)), 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush with a load held and a new instruction offered.
    send(LW_X5, 32'h400, w);
    flush = 1'b1;
    out_ready = 1'b0;
    inst = ADDI_5;
    pc = 32'h500;
    in_valid = 1'b1;
    @(negedge clk);
    check("fl_in_ready_a", 64'(in_ready_a), 64'd0);
    check("fl_in_ready_b", 64'(in_ready_b), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b1;
    inst = ADD_X6;
    pc = 32'h600;
    @(negedge clk);
    check("fl_out_valid_a", 64'(out_valid_a), 64'd0);
    check("fl_out_valid_b", 64'(out_valid_b), 64'd0);
    check("fl_ld_cleared",  64'(in_ready_a), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("fl_next_pc", 64'(pc_out_a), 64'h600);

    // Flush overrides an otherwise acceptable instruction.
    flush = 1'b1;
    inst = ADDI_5;
    pc = 32'h680;
    in_valid = 1'b1;
    @(negedge clk);
    check("fl_override", 64'(in_ready_a), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_override_valid", 64'(out_valid_a), 64'd0);

    // Illegal / configuration-dependent opcodes.
    for (int k = 0; k < 3; k++) begin
      send(ill_inst[k], 32'h700 + 32'(k * 4), w);
      check("ill_flag_a", 64'(illegal_a), 64'd1);
      check("ill_type_a", 64'(type_a), 64'(ill_type_a[k]));
      check("ill_ctrl_a", 64'({reg_write_a, mem_read_a, mem_write_a, branch_a, jump_a, alu_src_imm_a}), 64'd0);
      check("ill_flag_b", 64'(illegal_b), 64'(ill_flag_b[k]));
      check("ill_type_b", 64'(type_b), 64'(ill_type_b[k]));
    end

    // Asynchronous reset while an instruction is held.
    send(ADDI_5, 32'h800, w);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid_a), 64'd0);
    check("arst_pc",    64'(pc_out_a), 64'd0);
    check("arst_imm",   64'(imm_a), 64'd0);
    check("arst_type",  64'(type_b), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid_a), 64'd0);

    send(ADDI_5, 32'h900, w);
    @(negedge clk);
    @(negedge clk);
    check("sb_empty_a", 64'(q_a.size()), 64'd0);
    check("sb_empty_b", 64'(q_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
